// File: rtl/elevator_scheduler.sv
// SCAN elevator car scheduler: latches floor requests, picks targets,
// and times travel and door dwell on display frame boundaries.
module elevator_scheduler #(
  parameter int NUM_FLOORS         = 8,
  parameter int FLOOR_TRAVEL_TICKS = 60,
  parameter int DOOR_OPEN_TICKS    = 120
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FLOORS-1:0]         floor_req,
  input  logic                          frame_tick,
  output logic [NUM_FLOORS-1:0]         destination,
  output logic [1:0]                    sim_state,
  output logic [$clog2(NUM_FLOORS)-1:0] current_floor,
  output logic [NUM_FLOORS-1:0]         pending,
  output logic                          arrived
);

  localparam int FW = $clog2(NUM_FLOORS);
  localparam int MW = (FLOOR_TRAVEL_TICKS > 1) ? $clog2(FLOOR_TRAVEL_TICKS) : 1;
  localparam int DW = (DOOR_OPEN_TICKS > 1) ? $clog2(DOOR_OPEN_TICKS) : 1;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_UP    = 2'b01;
  localparam logic [1:0] S_DOWN  = 2'b10;
  localparam logic [1:0] S_DOORS = 2'b11;

  localparam logic [MW-1:0] MOVE_LAST = MW'(FLOOR_TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_OPEN_TICKS - 1);

  logic [1:0]            state_q, state_d;
  logic [FW-1:0]         cur_q, cur_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic [NUM_FLOORS-1:0] dest_q, dest_d;
  logic                  dir_q, dir_d;
  logic [MW-1:0]         mc_q, mc_d;
  logic [DW-1:0]         dc_q, dc_d;
  logic                  arr_q, arr_d;

  logic                  has_up, has_dn;
  logic [FW-1:0]         up_t, dn_t;
  logic                  tgt_ok, tgt_up;
  logic [FW-1:0]         tgt_f;
  logic [NUM_FLOORS-1:0] clr;

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    has_up = 1'b0;
    up_t   = '0;
    has_dn = 1'b0;
    dn_t   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pend_q[i] && (FW'(i) > cur_q)) begin
        has_up = 1'b1;
        up_t   = FW'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend_q[i] && (FW'(i) < cur_q)) begin
        has_dn = 1'b1;
        dn_t   = FW'(i);
      end
    end
  end

  always_comb begin
    tgt_ok = 1'b0;
    tgt_up = dir_q;
    tgt_f  = '0;
    if (dir_q) begin
      if (has_up) begin
        tgt_ok = 1'b1;
        tgt_up = 1'b1;
        tgt_f  = up_t;
      end else if (has_dn) begin
        tgt_ok = 1'b1;
        tgt_up = 1'b0;
        tgt_f  = dn_t;
      end
    end else begin
      if (has_dn) begin
        tgt_ok = 1'b1;
        tgt_up = 1'b0;
        tgt_f  = dn_t;
      end else if (has_up) begin
        tgt_ok = 1'b1;
        tgt_up = 1'b1;
        tgt_f  = up_t;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dir_d   = dir_q;
    mc_d    = mc_q;
    dc_d    = dc_q;
    dest_d  = dest_q;
    arr_d   = 1'b0;
    if (frame_tick) begin
      dest_d = tgt_ok ? (NUM_FLOORS'(1) << tgt_f) : '0;
      unique case (state_q)
        S_IDLE: begin
          if (pend_q[cur_q]) begin
            state_d = S_DOORS;
            dc_d    = '0;
            arr_d   = 1'b1;
          end else if (tgt_ok) begin
            state_d = tgt_up ? S_UP : S_DOWN;
            dir_d   = tgt_up;
            mc_d    = '0;
          end
        end
        S_UP, S_DOWN: begin
          if (mc_q == MOVE_LAST) begin
            mc_d  = '0;
            cur_d = (state_q == S_UP) ? cur_q + FW'(1) : cur_q - FW'(1);
            if (pend_q[cur_d]) begin
              state_d = S_DOORS;
              dc_d    = '0;
              arr_d   = 1'b1;
            end
          end else begin
            mc_d = mc_q + MW'(1);
          end
        end
        default: begin
          if (dc_q == DOOR_LAST) begin
            if (tgt_ok) begin
              state_d = tgt_up ? S_UP : S_DOWN;
              dir_d   = tgt_up;
              mc_d    = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            dc_d = dc_q + DW'(1);
          end
        end
      endcase
    end
    // A fresh call for this floor holds the doors open, tick or not.
    if (state_q == S_DOORS && floor_req[cur_q]) begin
      state_d = S_DOORS;
      dir_d   = dir_q;
      dc_d    = '0;
    end
  end

  always_comb begin
    clr    = (state_d == S_DOORS) ? (NUM_FLOORS'(1) << cur_d) : '0;
    pend_d = (pend_q | floor_req) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      pend_q  <= '0;
      dest_q  <= '0;
      dir_q   <= 1'b1;
      mc_q    <= '0;
      dc_q    <= '0;
      arr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      dest_q  <= dest_d;
      dir_q   <= dir_d;
      mc_q    <= mc_d;
      dc_q    <= dc_d;
      arr_q   <= arr_d;
    end
  end

  assign destination   = dest_q;
  assign sim_state     = state_q;
  assign current_floor = cur_q;
  assign pending       = pend_q;
  assign arrived       = arr_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with short travel and
// dwell times (2 ticks per floor, 3 ticks door dwell).
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] floor_req = '0;
  logic       frame_tick = 1'b0;
  logic [7:0] destination;
  logic [1:0] sim_state;
  logic [2:0] current_floor;
  logic [7:0] pending;
  logic       arrived;

  int checks = 0;
  int errors = 0;

  elevator_scheduler #(
    .NUM_FLOORS(8),
    .FLOOR_TRAVEL_TICKS(2),
    .DOOR_OPEN_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .floor_req(floor_req),
    .frame_tick(frame_tick),
    .destination(destination),
    .sim_state(sim_state),
    .current_floor(current_floor),
    .pending(pending),
    .arrived(arrived)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic req(input logic [7:0] m);
    @(negedge clk) floor_req = m;
    @(negedge clk) floor_req = '0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_floor"}, 32'(current_floor), 0);
    chk({tag, "_state"}, 32'(sim_state), 0);
    chk({tag, "_dest"}, 32'(destination), 0);
    chk({tag, "_pend"}, 32'(pending), 0);
    chk({tag, "_arr"}, 32'(arrived), 0);
  endtask

  initial begin
    do_reset();
    chk_reset_vals("rst");

    // Single trip 0 -> 3
    req(8'h08);
    chk("trip_pend", 32'(pending), 32'h08);
    tick_n(1);
    chk("trip_t1_state", 32'(sim_state), 1);
    chk("trip_t1_dest", 32'(destination), 32'h08);
    tick_n(2);
    chk("trip_t3_floor", 32'(current_floor), 1);
    tick_n(4);
    chk("trip_t7_floor", 32'(current_floor), 3);
    chk("trip_t7_state", 32'(sim_state), 3);
    chk("trip_t7_arr", 32'(arrived), 1);
    chk("trip_t7_pend", 32'(pending), 0);
    @(negedge clk);
    chk("trip_arr_pulse", 32'(arrived), 0);
    tick_n(2);
    chk("trip_t9_state", 32'(sim_state), 3);
    tick_n(1);
    chk("trip_t10_state", 32'(sim_state), 0);
    chk("trip_t10_dest", 32'(destination), 0);

    // Reverse to DOWN, then reset mid-motion
    req(8'h03);
    tick_n(1);
    chk("down_state", 32'(sim_state), 2);
    chk("down_dest", 32'(destination), 32'h02);
    chk("down_pend", 32'(pending), 32'h03);
    do_reset();
    chk_reset_vals("midrst");
    tick_n(1);
    chk("midrst_idle", 32'(sim_state), 0);

    // Travel 0 -> 2
    req(8'h04);
    tick_n(5);
    chk("to2_floor", 32'(current_floor), 2);
    chk("to2_state", 32'(sim_state), 3);
    tick_n(3);
    chk("to2_idle", 32'(sim_state), 0);

    // Same-floor request and dwell restart
    req(8'h04);
    tick_n(1);
    chk("same_state", 32'(sim_state), 3);
    chk("same_floor", 32'(current_floor), 2);
    chk("same_arr", 32'(arrived), 1);
    chk("same_pend", 32'(pending), 0);
    tick_n(2);
    req(8'h04);
    chk("restart_pend", 32'(pending), 0);
    chk("restart_state", 32'(sim_state), 3);
    tick_n(2);
    chk("restart_still_open", 32'(sim_state), 3);
    tick_n(1);
    chk("restart_closed", 32'(sim_state), 0);

    // SCAN ordering: up from 2 toward 5, inject 1 and 4
    req(8'h20);
    tick_n(1);
    chk("scan_up", 32'(sim_state), 1);
    chk("scan_dest5", 32'(destination), 32'h20);
    req(8'h12);
    chk("scan_pend", 32'(pending), 32'h32);
    tick_n(1);
    chk("scan_dest4", 32'(destination), 32'h10);
    tick_n(3);
    chk("scan_stop4_floor", 32'(current_floor), 4);
    chk("scan_stop4_state", 32'(sim_state), 3);
    chk("scan_stop4_pend", 32'(pending), 32'h22);
    tick_n(3);
    chk("scan_resume_up", 32'(sim_state), 1);
    chk("scan_resume_dest", 32'(destination), 32'h20);
    tick_n(2);
    chk("scan_stop5_floor", 32'(current_floor), 5);
    chk("scan_stop5_state", 32'(sim_state), 3);
    chk("scan_stop5_arr", 32'(arrived), 1);
    tick_n(3);
    chk("scan_rev_state", 32'(sim_state), 2);
    chk("scan_rev_dest", 32'(destination), 32'h02);
    tick_n(8);
    chk("scan_stop1_floor", 32'(current_floor), 1);
    chk("scan_stop1_state", 32'(sim_state), 3);
    chk("scan_stop1_pend", 32'(pending), 0);
    tick_n(3);
    chk("scan_end_idle", 32'(sim_state), 0);
    chk("scan_end_dest", 32'(destination), 0);

    // Frame alignment: no ticks for 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      floor_req = (i == 10) ? 8'h80 : 8'h00;
    end
    floor_req = '0;
    chk("frame_pend", 32'(pending), 32'h80);
    chk("frame_state", 32'(sim_state), 0);
    chk("frame_floor", 32'(current_floor), 1);
    chk("frame_dest", 32'(destination), 0);
    tick_n(1);
    chk("frame_go_up", 32'(sim_state), 1);
    chk("frame_go_dest", 32'(destination), 32'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
